io_block_cfg: RTL and testbench

- Parametrised successor to the fixed 4x8-bit programmable IO block.
- Per-output-channel source select and output mode, loaded through a serial config chain on the fabric clock.
- Shadow/active double buffering: a new config is committed only after an exact-length load; the live config keeps running during a load.
- prog_out daisy-chains to the next block's prog_in.

---
 rtl/io_block_cfg.sv | 155 +++++++++++++++
 tb/tb_io_block_cfg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/io_block_cfg.sv
// Programmable IO block: serial-loaded shadow config, committed to an active config that drives
// per-channel source-select/mode muxes. Define CFG_PARITY_EN to append an even-parity bit to the chain.
module io_block_chan #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int SRC_W    = 2
) (
  input  logic                      clb_clk,
  input  logic                      rst_n,
  input  logic [1:0]                mode_i,
  input  logic [SRC_W-1:0]          src_i,
  input  logic [CHANNELS*WIDTH-1:0] in_bus_i,
  output logic [WIDTH-1:0]          out_o
);
  logic [WIDTH-1:0] sel;
  logic             src_ok;
  logic [WIDTH-1:0] reg_d, reg_q;

  // Out-of-range sources (non-power-of-two CHANNELS) leave src_ok low and force zero in every mode.
  always_comb begin
    sel    = '0;
    src_ok = 1'b0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (src_i == SRC_W'(j)) begin
        sel    = in_bus_i[j*WIDTH +: WIDTH];
        src_ok = 1'b1;
      end
    end
  end

  always_comb begin
    reg_d = '0;
    if (src_ok) reg_d = mode_i[0] ? ~sel : sel;
  end

  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  always_comb begin
    case (mode_i)
      2'b00:   out_o = '0;
      2'b01:   out_o = sel;
      default: out_o = reg_q;
    endcase
  end
endmodule

module io_block_cfg #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clb_clk,
  input  logic                      rst_n,
  input  logic                      prog_in,
  input  logic                      prog_en,
  output logic                      prog_out,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  output logic [CHANNELS*WIDTH-1:0] out_bus,
  output logic                      busy,
  output logic                      cfg_valid,
  output logic                      cfg_err
);
  localparam int SRC_W    = $clog2(CHANNELS);
  localparam int FIELD_W  = SRC_W + 2;
  localparam int CFG_BITS = CHANNELS * FIELD_W;
`ifdef CFG_PARITY_EN
  localparam int CHAIN    = CFG_BITS + 1;
`else
  localparam int CHAIN    = CFG_BITS;
`endif
  localparam int CNT_MAX  = CHAIN + 1;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e              state_q;
  logic [CFG_BITS-1:0] shadow_q, active_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                prog_out_q, busy_q, cfg_valid_q, cfg_err_q;
  logic                shift_in;
  logic                commit_ok;

`ifdef CFG_PARITY_EN
  logic par_q;
  // Parity stage sits ahead of the shadow, so it holds the last (parity) bit of an exact load.
  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n)       par_q <= 1'b0;
    else if (prog_en) par_q <= prog_in;
  end
  assign shift_in  = par_q;
  assign commit_ok = (cnt_q == CNT_W'(CHAIN)) && !(^{par_q, shadow_q});
`else
  assign shift_in  = prog_in;
  assign commit_ok = (cnt_q == CNT_W'(CHAIN));
`endif

  always_ff @(posedge clb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      active_q    <= '0;
      cnt_q       <= '0;
      prog_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (prog_en) begin
        shadow_q   <= {shift_in, shadow_q[CFG_BITS-1:1]};
        prog_out_q <= shadow_q[0];
      end
      case (state_q)
        IDLE: if (prog_en) begin
          state_q <= SHIFT;
          busy_q  <= 1'b1;
          cnt_q   <= CNT_W'(1);
        end
        SHIFT: begin
          if (prog_en) begin
            if (cnt_q != CNT_W'(CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (commit_ok) begin
              active_q    <= shadow_q;
              cfg_valid_q <= 1'b1;
              cfg_err_q   <= 1'b0;
            end else begin
              cfg_err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prog_out  = prog_out_q;
  assign busy      = busy_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_err   = cfg_err_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    io_block_chan #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .SRC_W(SRC_W)) u_chan (
      .clb_clk  (clb_clk),
      .rst_n    (rst_n),
      .mode_i   (active_q[k*FIELD_W+SRC_W +: 2]),
      .src_i    (active_q[k*FIELD_W +: SRC_W]),
      .in_bus_i (in_bus),
      .out_o    (out_bus[k*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_io_block_cfg.sv
// Scoreboard bench for io_block_cfg: reference model of the config chain and channel muxes.
module tb_io_block_cfg;
  localparam int CH = 4, W = 8, SW = 2, FW = 4, CB = 16;
`ifdef CFG_PARITY_EN
  localparam int CHAIN = CB + 1;
`else
  localparam int CHAIN = CB;
`endif

  logic          clb_clk = 1'b0, rst_n = 1'b0, prog_in = 1'b0, prog_en = 1'b0;
  logic [CH*W-1:0] in_bus = '0, out_bus;
  logic          prog_out, busy, cfg_valid, cfg_err;

  io_block_cfg dut (
    .clb_clk(clb_clk), .rst_n(rst_n), .prog_in(prog_in), .prog_en(prog_en),
    .prog_out(prog_out), .in_bus(in_bus), .out_bus(out_bus),
    .busy(busy), .cfg_valid(cfg_valid), .cfg_err(cfg_err)
  );

  always #5 clb_clk = ~clb_clk;

  typedef struct {
    logic [CH*W-1:0] out;
    logic [CH*W-1:0] mask;  // 1 = don't care
    logic busy, valid, err, pout;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, errors = 0;

  // Reference model: the chain is a FIFO of every bit shifted since reset, oldest at the front.
  bit        chainq[$];
  int        mode_m[CH], src_m[CH];
  bit        loading, v_m, e_m, po_m, fresh;
  int        cnt_m;
  logic [CH*W-1:0] prev_in;
  logic [CH*W-1:0] IN0 = {8'hA5, 8'h3C, 8'h0F, 8'h81};

  function automatic void model_reset();
    chainq = {};
    for (int i = 0; i < CHAIN; i++) chainq.push_back(1'b0);
    for (int k = 0; k < CH; k++) begin mode_m[k] = 0; src_m[k] = 0; end
    loading = 0; v_m = 0; e_m = 0; po_m = 0; fresh = 0; cnt_m = 0; prev_in = '0;
  endfunction

  function automatic logic [W-1:0] pick(int k, logic [CH*W-1:0] bus);
    logic [W-1:0] v;
    if (src_m[k] >= CH) return '0;
    v = bus[src_m[k]*W +: W];
    return (mode_m[k] == 3) ? ~v : v;
  endfunction

  task automatic step(bit pen, bit pin, logic [CH*W-1:0] ib);
    exp_t e;
    bit   par;
    prog_en = pen; prog_in = pin; in_bus = ib;
    e.out = '0; e.mask = '0;
    for (int k = 0; k < CH; k++) begin
      case (mode_m[k])
        0: e.out[k*W +: W] = '0;
        1: e.out[k*W +: W] = pick(k, ib);
        default: begin
          e.out[k*W +: W] = pick(k, prev_in);
          if (fresh) e.mask[k*W +: W] = '1;
        end
      endcase
    end
    e.busy = loading; e.valid = v_m; e.err = e_m; e.pout = po_m;
    sbq.push_back(e);
    @(posedge clb_clk); #1;
    if (rst_n) begin
      fresh = 0;
      if (pen) begin
        chainq.push_back(pin);
        po_m = chainq.pop_front();
        cnt_m = loading ? cnt_m + 1 : 1;
        loading = 1;
      end else if (loading) begin
        loading = 0;
        par = 0;
        foreach (chainq[i]) par ^= chainq[i];
`ifndef CFG_PARITY_EN
        par = 0;
`endif
        if (cnt_m == CHAIN && !par) begin
          for (int k = 0; k < CH; k++) begin
            src_m[k]  = 0;
            for (int i = 0; i < SW; i++) src_m[k] += int'(chainq[k*FW+i]) << i;
            mode_m[k] = int'(chainq[k*FW+SW]) + 2*int'(chainq[k*FW+SW+1]);
          end
          v_m = 1; e_m = 0; fresh = 1;
        end else e_m = 1;
      end
      prev_in = ib;
    end
  endtask

  task automatic send(logic [63:0] bits, int n, logic [CH*W-1:0] ib, bit rnd);
    for (int i = 0; i < n; i++) step(1'b1, bits[i], rnd ? {$urandom, $urandom} : ib);
    step(1'b0, 1'b0, rnd ? {$urandom, $urandom} : ib);
  endtask

  function automatic logic [63:0] good_bits(logic [15:0] w);
    logic [63:0] b;
    b = {48'h0, w};
`ifdef CFG_PARITY_EN
    b[CB] = ^w;
`endif
    return b;
  endfunction

  always @(negedge clb_clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      vectors++;
      if (((out_bus & ~e.mask) !== (e.out & ~e.mask)) || busy !== e.busy ||
          cfg_valid !== e.valid || cfg_err !== e.err || prog_out !== e.pout) begin
        errors++;
        $display("FAIL vec%0d: got out=%h busy=%b valid=%b err=%b pout=%b, exp out=%h(mask %h) busy=%b valid=%b err=%b pout=%b",
                 vectors, out_bus, busy, cfg_valid, cfg_err, prog_out,
                 e.out, e.mask, e.busy, e.valid, e.err, e.pout);
      end
    end
  end

  initial begin
    logic [CH*W-1:0] ib;
    int n;
    model_reset();
    @(posedge clb_clk); #1;
    // Reset state with inputs driven.
    step(0, 0, IN0); step(0, 0, IN0);
    rst_n = 1'b1;
    step(0, 0, IN0); step(0, 0, IN0);

    // Good load, then let registered channels settle.
    send(good_bits(16'h0D87), CHAIN, IN0, 0);
    repeat (3) step(0, 0, IN0);

    // Bad lengths, then recovery.
    send(good_bits(16'h0D87), CHAIN - 1, IN0, 0);
    step(0, 0, IN0);
    send(good_bits(16'h0D87), CHAIN + 1, IN0, 0);
    step(0, 0, IN0);
    send(good_bits(16'h0D87), CHAIN, IN0, 0);
    repeat (2) step(0, 0, IN0);

    // Latency: comb channel follows ch3 immediately, registered one cycle later.
    ib = IN0; ib[31:24] = 8'h5A;
    step(0, 0, ib);
    ib[7:0] = 8'h18;
    repeat (3) step(0, 0, ib);

    // Daisy chain: payload followed by zeros; rejected for length.
    send({32'h0, 16'h0000, 16'h0D87}, 32, IN0, 0);
    step(0, 0, IN0);

`ifdef CFG_PARITY_EN
    send({47'h0, 1'b0, 16'h0D87}, CHAIN, IN0, 0);
    step(0, 0, IN0);
`endif

    // Reset mid-load, then a normal load.
    for (int i = 0; i < 8; i++) step(1, good_bits(16'h0D87)[i], IN0);
    rst_n = 1'b0;
    model_reset();
    step(0, 0, IN0); step(0, 0, IN0);
    rst_n = 1'b1;
    step(0, 0, IN0);
    send(good_bits(16'h0D87), CHAIN, IN0, 0);
    repeat (2) step(0, 0, IN0);

    // Randomized loads with random data, lengths and inputs.
    for (int t = 0; t < 40; t++) begin
      logic [63:0] b;
      b = good_bits(16'($urandom));
      n = CHAIN - 1 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) b[CHAIN-1] = ~b[CHAIN-1];
      send(b, n, '0, 1);
      repeat ($urandom_range(0, 4)) step(0, 0, {$urandom, $urandom});
    end
    repeat (2) step(0, 0, IN0);

    repeat (3) @(negedge clb_clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
